// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding,
// default operand width and the full-adder carry function.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Majority of three inputs: the carry out of a full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle between the lab top level and the serial
// subtractor. The current FSM state is carried alongside for observation.
//
// Handshake: the master raises start with a and b valid. start is accepted
// only while the subtractor is idle (busy=0, done=0). Once it is accepted,
// busy stays high while the bits are processed and done pulses for one
// cycle when diff/borrow/ovf become valid. The results then hold until the
// next accepted start. start seen while busy or done is dropped, not queued.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  state_e           state;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ovf, state
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ovf, state
  );

endinterface

// File: rtl/serial_subtractor_fa_cell.sv
// Single-bit full adder used as the arithmetic core of the serial subtractor.
module fa_cell
  import serial_subtractor_pkg::*;
(
  output logic s,
  output logic cout,
  input  logic x,
  input  logic y,
  input  logic cin
);

  // Purely combinational sum and carry.
  always_comb begin
    s    = x ^ y ^ cin;
    cout = maj3(x, y, cin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor. It computes a - b as a + ~b + 1,
// one bit per clock with the LSB first, through a single full-adder cell.
// The carry register starts at 1 and supplies the +1.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)(
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state;
  state_e           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_q;
  logic             carry;
  logic             borrow_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt;
  logic             sum;
  logic             cout;
  logic             b_inv;

  assign b_inv = ~b_sh[0];

  fa_cell u_fa (
    .s    (sum),
    .cout (cout),
    .x    (a_sh[0]),
    .y    (b_inv),
    .cin  (carry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_SHIFT;
      S_SHIFT: begin
        bus.busy = 1'b1;
        if (cnt == LAST_BIT) state_next = S_DONE;
      end
      S_DONE: begin
        bus.done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture, one bit of subtraction per SHIFT cycle, and the flags
  // taken from the MSB step.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      diff_q   <= '0;
      carry    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            carry    <= 1'b1;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
          end
        end
        S_SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= cout;
          diff_q <= {sum, diff_q[WIDTH-1:1]};
          if (cnt == LAST_BIT) begin
            // Here carry holds the carry into the MSB.
            borrow_q <= ~cout;
            ovf_q    <= carry ^ cout;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Result outputs.
  always_comb begin
    bus.diff   = diff_q;
    bus.borrow = borrow_q;
    bus.ovf    = ovf_q;
    bus.state  = state;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with WIDTH=8. Inputs are driven on
// the falling edge and outputs are sampled on the falling edge. A value
// sampled after rising edge k is the value the DUT presents at edge k+1.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation: start at edge 0, busy seen at edges 1..8, done at
  // edge 9, back to idle at edge 10. The operands change after capture.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int busy_cycles;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = ~bv;
    busy_cycles = 0;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1 && bus.done === 1'b0) busy_cycles++;
    end
    check({tag, "_busy_cycles"}, busy_cycles, W);
    @(negedge clk);
    check({tag, "_done"},   bus.done,   1'b1);
    check({tag, "_busy0"},  bus.busy,   1'b0);
    check({tag, "_diff"},   bus.diff,   ed);
    check({tag, "_borrow"}, bus.borrow, eb);
    check({tag, "_ovf"},    bus.ovf,    eo);
    @(negedge clk);
    check({tag, "_done_low"}, bus.done,  1'b0);
    check({tag, "_idle"},     bus.state, S_IDLE);
  endtask

  initial begin
    int held;
    int done_cnt;
    int done_at;
    logic [W-1:0] done_diff;

    tests = 0;
    fails = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   bus.busy,   1'b0);
    check("rst_done",   bus.done,   1'b0);
    check("rst_diff",   bus.diff,   8'h00);
    check("rst_borrow", bus.borrow, 1'b0);
    check("rst_ovf",    bus.ovf,    1'b0);
    check("rst_state",  bus.state,  S_IDLE);
    rst = 1'b0;

    // Basic subtraction, borrow, and signed overflow.
    run_op("sub_5_3", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op("sub_3_5", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);

    // The result holds through idle cycles.
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.diff === 8'hFE && bus.borrow === 1'b1 && bus.done === 1'b0) held++;
    end
    check("hold_20", held, 20);

    run_op("ovf_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("ovf_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    run_op("zero",      8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("ident_a5",  8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);

    // A start raised 3 cycles into SHIFT is ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h05;
    bus.b     = 8'h03;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    done_cnt  = 0;
    done_at   = 0;
    done_diff = '0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at   = k + 1;
        done_diff = bus.diff;
      end
      if (k == 2) begin
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
      end else if (k == 3) begin
        bus.start = 1'b0;
      end
    end
    check("hs_done_count", done_cnt,  1);
    check("hs_done_edge",  done_at,   9);
    check("hs_diff",       done_diff, 8'h02);

    // Reset during bit 4 discards the partial result.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h5A;
    bus.b     = 8'h21;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int e = 1; e <= 4; e++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",   bus.busy,   1'b0);
    check("mid_rst_done",   bus.done,   1'b0);
    check("mid_rst_diff",   bus.diff,   8'h00);
    check("mid_rst_borrow", bus.borrow, 1'b0);
    check("mid_rst_ovf",    bus.ovf,    1'b0);
    check("mid_rst_state",  bus.state,  S_IDLE);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_cnt++;
    end
    check("mid_rst_no_done", done_cnt, 0);
    run_op("after_rst", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
